// File: rtl/median_result_actor.sv
// median_result_actor: terminal actor of the median-filter chain.
// Latches a window header, stores up to BUFF_SIZE pixels (excess pixels are
// consumed and dropped), then finds the rank-pos element by exhaustive rank
// counting and writes one median byte downstream.
// Optional feature: define MEDIAN_RESULT_AVG_EN to emit the rounded average of
// the selected element and the second-median token (even-length median).
module median_result_actor #(
  parameter logic [10:0] BUFF_SIZE     = 11'd16,
  parameter int          BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_px,
  output logic                     in_px_rd,
  input  logic                     in_px_empty,
  input  logic [7:0]               in_pivot,
  output logic                     in_pivot_rd,
  input  logic                     in_pivot_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  output logic                     in_buff_size_rd,
  input  logic                     in_buff_size_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
  output logic                     in_median_pos_rd,
  input  logic                     in_median_pos_empty,
  input  logic [7:0]               in_second_median_value,
  output logic                     in_second_median_value_rd,
  input  logic                     in_second_median_value_empty,
  output logic [7:0]               out_median,
  output logic                     out_median_wr,
  input  logic                     out_median_full,
  output logic                     busy
);

  localparam int IDX_W = BUFF_SIZE_BIT - 1;
  localparam logic [BUFF_SIZE_BIT-1:0] CAP  = BUFF_SIZE[BUFF_SIZE_BIT-1:0];
  localparam logic [BUFF_SIZE_BIT-1:0] ZERO = '0;
  localparam logic [BUFF_SIZE_BIT-1:0] ONE  = {{(BUFF_SIZE_BIT-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StHdr, StFill, StScan, StEmit} state_e;

  state_e state_q, state_d;

  logic [BUFF_SIZE_BIT-1:0] size_q, total_q, pos_q, cons_q;
  logic [BUFF_SIZE_BIT-1:0] i_q, j_q, lt_q, le_q;
  logic [7:0]               result_q;
  logic [7:0]               mem [0:BUFF_SIZE-1];

  logic [BUFF_SIZE_BIT-1:0] hdr_size, hdr_pos, lt_nxt, le_nxt;
  logic [7:0]               mem_i, mem_j, hdr_result, scan_result;
  logic                     hdrs_ready, scan_last, hit;

`ifdef MEDIAN_RESULT_AVG_EN
  logic [7:0] second_q;

  // Rounded mean of two bytes using a 9-bit sum.
  function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return sum[8:1];
  endfunction
`else
  // The second-median token is still popped in HDR but carries no meaning here.
  logic unused_second;
  assign unused_second = ^in_second_median_value;
`endif

  // Header decode and rank-count datapath.
  always_comb begin
    hdr_size  = (in_buff_size > CAP) ? CAP : in_buff_size;
    hdr_pos   = (in_median_pos > hdr_size - ONE) ? hdr_size - ONE : in_median_pos;
    mem_i     = mem[i_q[IDX_W-1:0]];
    mem_j     = mem[j_q[IDX_W-1:0]];
    lt_nxt    = lt_q + {{(BUFF_SIZE_BIT-1){1'b0}}, (mem_j < mem_i)};
    le_nxt    = le_q + {{(BUFF_SIZE_BIT-1){1'b0}}, (mem_j <= mem_i)};
    scan_last = (j_q == size_q - ONE);
    hit       = (lt_nxt <= pos_q) && (pos_q < le_nxt);
`ifdef MEDIAN_RESULT_AVG_EN
    hdr_result  = avg_round(in_pivot, in_second_median_value);
    scan_result = avg_round(mem_i, second_q);
`else
    hdr_result  = in_pivot;
    scan_result = mem_i;
`endif
  end

  assign hdrs_ready = ~in_pivot_empty & ~in_buff_size_empty & ~in_median_pos_empty &
                      ~in_second_median_value_empty;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state and FIFO handshake outputs.
  always_comb begin
    state_d                   = state_q;
    in_px_rd                  = 1'b0;
    in_pivot_rd               = 1'b0;
    in_buff_size_rd           = 1'b0;
    in_median_pos_rd          = 1'b0;
    in_second_median_value_rd = 1'b0;
    out_median_wr             = 1'b0;
    unique case (state_q)
      StIdle: if (hdrs_ready) state_d = StHdr;
      StHdr: begin
        in_pivot_rd               = 1'b1;
        in_buff_size_rd           = 1'b1;
        in_median_pos_rd          = 1'b1;
        in_second_median_value_rd = 1'b1;
        state_d = (in_buff_size == ZERO) ? StEmit : StFill;
      end
      StFill: begin
        in_px_rd = ~in_px_empty;
        if (~in_px_empty && (cons_q + ONE == total_q)) state_d = StScan;
      end
      StScan: if (scan_last && hit) state_d = StEmit;
      StEmit: begin
        out_median_wr = ~out_median_full;
        if (~out_median_full) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Header latches, fill/drop counter, scan counters and result register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      size_q   <= '0;
      total_q  <= '0;
      pos_q    <= '0;
      cons_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      lt_q     <= '0;
      le_q     <= '0;
      result_q <= '0;
`ifdef MEDIAN_RESULT_AVG_EN
      second_q <= '0;
`endif
    end else begin
      case (state_q)
        StHdr: begin
          size_q  <= hdr_size;
          total_q <= in_buff_size;
          pos_q   <= hdr_pos;
          cons_q  <= '0;
          i_q     <= '0;
          j_q     <= '0;
          lt_q    <= '0;
          le_q    <= '0;
`ifdef MEDIAN_RESULT_AVG_EN
          second_q <= in_second_median_value;
`endif
          if (in_buff_size == ZERO) result_q <= hdr_result;
        end
        StFill: if (~in_px_empty) cons_q <= cons_q + ONE;
        StScan: begin
          if (scan_last) begin
            // End of a candidate: either it owns rank pos or move to the next one.
            if (hit) result_q <= scan_result;
            else     i_q      <= i_q + ONE;
            j_q  <= '0;
            lt_q <= '0;
            le_q <= '0;
          end else begin
            j_q  <= j_q + ONE;
            lt_q <= lt_nxt;
            le_q <= le_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel store; only the first size pixels of a window are kept.
  always_ff @(posedge clock) begin
    if (state_q == StFill && ~in_px_empty && cons_q < size_q) begin
      mem[cons_q[IDX_W-1:0]] <= in_px;
    end
  end

  assign out_median = result_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_median_result_actor.sv
// Directed bench for median_result_actor: FWFT FIFO models on every input,
// a write monitor on the output, one task per scenario.
module tb_median_result_actor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_px, in_pivot, in_second_median_value, out_median;
  logic [4:0] in_buff_size, in_median_pos;
  logic       in_px_rd, in_px_empty, in_pivot_rd, in_pivot_empty;
  logic       in_buff_size_rd, in_buff_size_empty, in_median_pos_rd, in_median_pos_empty;
  logic       in_second_median_value_rd, in_second_median_value_empty;
  logic       out_median_wr, busy;
  logic       out_median_full = 1'b0;
  logic       px_stall = 1'b0;

  // FIFO contents: write pointers owned by tasks, read pointers by the monitor.
  logic [7:0] px_mem [0:255];
  logic [7:0] hp_mem [0:63];
  logic [4:0] hs_mem [0:63];
  logic [4:0] hm_mem [0:63];
  logic [7:0] hv_mem [0:63];
  int px_wp = 0, px_rp = 0, hdr_wp = 0;
  int piv_rp = 0, bs_rp = 0, mp_rp = 0, sv_rp = 0;

  int cyc = 0, wr_count = 0, wr_cyc = 0, px_reads = 0, last_rd_cyc = 0;
  int viol_rd_empty = 0, viol_wr_full = 0, viol_hdr_empty = 0;
  logic [7:0] last_out = 8'd0;
  int checks = 0, fails = 0;

  logic [7:0] over_px [0:17] = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20,
                                  8'd25, 8'd35, 8'd45, 8'd55, 8'd65, 8'd75, 8'd85, 8'd95,
                                  8'd5, 8'd3};

  assign in_px                        = px_mem[px_rp];
  assign in_px_empty                  = (px_rp == px_wp) || px_stall;
  assign in_pivot                     = hp_mem[piv_rp];
  assign in_pivot_empty               = (piv_rp == hdr_wp);
  assign in_buff_size                 = hs_mem[bs_rp];
  assign in_buff_size_empty           = (bs_rp == hdr_wp);
  assign in_median_pos                = hm_mem[mp_rp];
  assign in_median_pos_empty          = (mp_rp == hdr_wp);
  assign in_second_median_value       = hv_mem[sv_rp];
  assign in_second_median_value_empty = (sv_rp == hdr_wp);

  median_result_actor dut (
    .clock                        (clock),
    .reset                        (reset),
    .in_px                        (in_px),
    .in_px_rd                     (in_px_rd),
    .in_px_empty                  (in_px_empty),
    .in_pivot                     (in_pivot),
    .in_pivot_rd                  (in_pivot_rd),
    .in_pivot_empty               (in_pivot_empty),
    .in_buff_size                 (in_buff_size),
    .in_buff_size_rd              (in_buff_size_rd),
    .in_buff_size_empty           (in_buff_size_empty),
    .in_median_pos                (in_median_pos),
    .in_median_pos_rd             (in_median_pos_rd),
    .in_median_pos_empty          (in_median_pos_empty),
    .in_second_median_value       (in_second_median_value),
    .in_second_median_value_rd    (in_second_median_value_rd),
    .in_second_median_value_empty (in_second_median_value_empty),
    .out_median                   (out_median),
    .out_median_wr                (out_median_wr),
    .out_median_full              (out_median_full),
    .busy                         (busy)
  );

  always #5 clock = ~clock;

  // FIFO pops, output capture and protocol violation counters.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (in_px_rd && !in_px_empty) begin
      px_rp       <= px_rp + 1;
      px_reads    <= px_reads + 1;
      last_rd_cyc <= cyc + 1;
    end
    if (in_pivot_rd && !in_pivot_empty) piv_rp <= piv_rp + 1;
    if (in_buff_size_rd && !in_buff_size_empty) bs_rp <= bs_rp + 1;
    if (in_median_pos_rd && !in_median_pos_empty) mp_rp <= mp_rp + 1;
    if (in_second_median_value_rd && !in_second_median_value_empty) sv_rp <= sv_rp + 1;
    if (out_median_wr && !out_median_full) begin
      wr_count <= wr_count + 1;
      last_out <= out_median;
      wr_cyc   <= cyc + 1;
    end
    if (in_px_rd && in_px_empty) viol_rd_empty <= viol_rd_empty + 1;
    if (out_median_wr && out_median_full) viol_wr_full <= viol_wr_full + 1;
    if ((in_pivot_rd && in_pivot_empty) || (in_buff_size_rd && in_buff_size_empty))
      viol_hdr_empty <= viol_hdr_empty + 1;
  end

  task automatic push_px(input logic [7:0] v);
    px_mem[px_wp] = v;
    px_wp++;
  endtask

  task automatic push_hdr(input logic [7:0] piv, input logic [4:0] bs, input logic [4:0] mp,
                          input logic [7:0] sv);
    hp_mem[hdr_wp] = piv;
    hs_mem[hdr_wp] = bs;
    hm_mem[hdr_wp] = mp;
    hv_mem[hdr_wp] = sv;
    hdr_wp++;
  endtask

  task automatic wait_write(input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (wr_count > prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    checks++;
    if ({in_px_rd, in_pivot_rd, in_buff_size_rd, in_median_pos_rd,
         in_second_median_value_rd} !== 5'b0) begin
      fails++;
      $display("FAIL reset_rd: got %b want 00000", {in_px_rd, in_pivot_rd, in_buff_size_rd,
               in_median_pos_rd, in_second_median_value_rd});
    end
    checks++;
    if (out_median_wr !== 1'b0) begin
      fails++;
      $display("FAIL reset_wr: got %b want 0", out_median_wr);
    end
    checks++;
    if (out_median !== 8'd0) begin
      fails++;
      $display("FAIL reset_out: got %0d want 0", out_median);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic;
    int w0;
    bit ok;
    logic [7:0] exp;
`ifdef MEDIAN_RESULT_AVG_EN
    exp = 8'd3;
`else
    exp = 8'd5;
`endif
    w0 = wr_count;
    push_px(8'd5); push_px(8'd3); push_px(8'd9); push_px(8'd1);
    push_hdr(8'd127, 5'd4, 5'd2, 8'd0);
    wait_write(w0, 100, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL basic_timeout: got no write want 1 write");
    end
    checks++;
    if (last_out !== exp) begin
      fails++;
      $display("FAIL basic_value: got %0d want %0d", last_out, exp);
    end
    checks++;
    if (wr_cyc - last_rd_cyc - 1 != 4) begin
      fails++;
      $display("FAIL basic_scan_cycles: got %0d want 4", wr_cyc - last_rd_cyc - 1);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (wr_count - w0 != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_single_write: got %0d writes busy %b want 1 writes busy 0",
               wr_count - w0, busy);
    end
  endtask

  task automatic test_size_zero;
    int w0, p0, c0;
    bit ok;
    logic [7:0] exp;
`ifdef MEDIAN_RESULT_AVG_EN
    exp = 8'd26;
`else
    exp = 8'd42;
`endif
    w0 = wr_count;
    p0 = px_reads;
    c0 = cyc;
    push_hdr(8'd42, 5'd0, 5'd0, 8'd10);
    wait_write(w0, 20, ok);
    checks++;
    if (!ok || last_out !== exp) begin
      fails++;
      $display("FAIL size0_value: got %0d (written %b) want %0d", last_out, ok, exp);
    end
    checks++;
    if (wr_cyc - c0 > 3) begin
      fails++;
      $display("FAIL size0_latency: got %0d cycles want <= 3", wr_cyc - c0);
    end
    checks++;
    if (px_reads != p0) begin
      fails++;
      $display("FAIL size0_px_reads: got %0d want 0", px_reads - p0);
    end
  endtask

  task automatic test_duplicates;
    int w0;
    bit ok;
    logic [7:0] exp;
`ifdef MEDIAN_RESULT_AVG_EN
    exp = 8'd8;
`else
    exp = 8'd7;
`endif
    w0 = wr_count;
    push_px(8'd7); push_px(8'd7); push_px(8'd7); push_px(8'd2);
    push_hdr(8'd127, 5'd4, 5'd3, 8'd9);
    wait_write(w0, 100, ok);
    checks++;
    if (!ok || last_out !== exp) begin
      fails++;
      $display("FAIL dup_value: got %0d (written %b) want %0d", last_out, ok, exp);
    end
  endtask

  task automatic test_oversize;
    int w0, p0, h0;
    bit ok;
    logic [7:0] exp;
`ifdef MEDIAN_RESULT_AVG_EN
    exp = 8'd10;
`else
    exp = 8'd20;
`endif
    w0 = wr_count;
    p0 = px_reads;
    h0 = hdr_wp;
    for (int k = 0; k < 18; k++) push_px(over_px[k]);
    push_hdr(8'd127, 5'd18, 5'd0, 8'd0);
    push_hdr(8'd77, 5'd0, 5'd0, 8'd77);
    wait_write(w0, 400, ok);
    checks++;
    if (!ok || last_out !== exp) begin
      fails++;
      $display("FAIL over_value: got %0d (written %b) want %0d", last_out, ok, exp);
    end
    checks++;
    if (px_reads - p0 != 18) begin
      fails++;
      $display("FAIL over_px_reads: got %0d want 18", px_reads - p0);
    end
    checks++;
    if (piv_rp != h0 + 1 || bs_rp != h0 + 1) begin
      fails++;
      $display("FAIL over_next_hdr: got rp %0d/%0d want %0d", piv_rp, bs_rp, h0 + 1);
    end
    wait_write(w0 + 1, 20, ok);
    checks++;
    if (!ok || last_out !== 8'd77) begin
      fails++;
      $display("FAIL over_next_value: got %0d (written %b) want 77", last_out, ok);
    end
  endtask

  task automatic test_full_stall;
    int w0;
    bit ok;
    logic [7:0] exp;
`ifdef MEDIAN_RESULT_AVG_EN
    exp = 8'd2;
`else
    exp = 8'd4;
`endif
    w0 = wr_count;
    out_median_full = 1'b1;
    push_px(8'd4); push_px(8'd8);
    push_hdr(8'd127, 5'd2, 5'd0, 8'd0);
    repeat (11) @(negedge clock);
    checks++;
    if (wr_count != w0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL full_hold: got %0d writes busy %b want 0 writes busy 1",
               wr_count - w0, busy);
    end
    out_median_full = 1'b0;
    wait_write(w0, 10, ok);
    checks++;
    if (!ok || last_out !== exp) begin
      fails++;
      $display("FAIL full_value: got %0d (written %b) want %0d", last_out, ok, exp);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (wr_count - w0 != 1) begin
      fails++;
      $display("FAIL full_write_count: got %0d want 1", wr_count - w0);
    end
    checks++;
    if (viol_wr_full != 0) begin
      fails++;
      $display("FAIL full_wr_while_full: got %0d want 0", viol_wr_full);
    end
  endtask

  task automatic test_px_stall;
    int w0, p0;
    bit ok;
    w0 = wr_count;
    p0 = px_reads;
    ok = 1'b0;
    push_px(8'd20); push_px(8'd10); push_px(8'd30);
    push_hdr(8'd127, 5'd3, 5'd1, 8'd20);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      px_stall = ~px_stall;
      if (wr_count > w0) begin
        ok = 1'b1;
        break;
      end
    end
    px_stall = 1'b0;
    checks++;
    if (!ok || last_out !== 8'd20) begin
      fails++;
      $display("FAIL stall_value: got %0d (written %b) want 20", last_out, ok);
    end
    checks++;
    if (px_reads - p0 != 3) begin
      fails++;
      $display("FAIL stall_px_reads: got %0d want 3", px_reads - p0);
    end
    checks++;
    if (viol_rd_empty != 0) begin
      fails++;
      $display("FAIL stall_rd_while_empty: got %0d want 0", viol_rd_empty);
    end
  endtask

  task automatic test_reset_mid_scan;
    int w0, p0;
    bit ok;
    w0 = wr_count;
    p0 = px_reads;
    for (int k = 0; k < 16; k++) push_px(8'((k + 1) * 10));
    push_hdr(8'd127, 5'd16, 5'd15, 8'd160);
    for (int k = 0; k < 40 && px_reads - p0 < 16; k++) @(negedge clock);
    repeat (20) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_busy: got %b want 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_median !== 8'd0 || out_median_wr !== 1'b0) begin
      fails++;
      $display("FAIL rst_outputs: got busy %b out %0d wr %b want 0 0 0",
               busy, out_median, out_median_wr);
    end
    checks++;
    if ({in_px_rd, in_pivot_rd, in_buff_size_rd, in_median_pos_rd,
         in_second_median_value_rd} !== 5'b0) begin
      fails++;
      $display("FAIL rst_rd: got %b want 00000", {in_px_rd, in_pivot_rd, in_buff_size_rd,
               in_median_pos_rd, in_second_median_value_rd});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (wr_count != w0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_abort: got %0d writes busy %b want 0 writes busy 0",
               wr_count - w0, busy);
    end
    push_px(8'd50); push_px(8'd60); push_px(8'd40);
    push_hdr(8'd127, 5'd3, 5'd2, 8'd60);
    wait_write(w0, 100, ok);
    checks++;
    if (!ok || last_out !== 8'd60) begin
      fails++;
      $display("FAIL rst_clean_value: got %0d (written %b) want 60", last_out, ok);
    end
    checks++;
    if (viol_hdr_empty != 0) begin
      fails++;
      $display("FAIL hdr_rd_while_empty: got %0d want 0", viol_hdr_empty);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_size_zero;
    test_duplicates;
    test_oversize;
    test_full_stall;
    test_px_stall;
    test_reset_mid_scan;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
